// File: rtl/systolic_edge_feeder.sv
`default_nettype none
// systolic_edge_feeder: holds operand matrices A/B and streams them, diagonally skewed,
// into the west/north edges of an N x N systolic array.  rev 1.0
module systolic_edge_feeder #(
  parameter int WIDTH = 4,
  parameter int N     = 3,
  parameter int AW    = $clog2(N*N)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               load_en,
  input  logic               load_sel,
  input  logic [AW-1:0]      load_addr,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               Clear,
  output logic [N*WIDTH-1:0] A_EDGE,
  output logic [N*WIDTH-1:0] B_EDGE
);

  localparam int DEPTH = N*N;
  localparam int KW    = $clog2(3*N);
  localparam logic [KW-1:0] K_LAST = KW'(3*N-3);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               clear_q, clear_d;
  logic [N*WIDTH-1:0] a_edge_q, a_edge_d;
  logic [N*WIDTH-1:0] b_edge_q, b_edge_d;
  logic [WIDTH-1:0]   a_q [DEPTH];
  logic [WIDTH-1:0]   a_d [DEPTH];
  logic [WIDTH-1:0]   b_q [DEPTH];
  logic [WIDTH-1:0]   b_d [DEPTH];
  logic               stream_en;
  logic [KW-1:0]      edge_k;

  always_comb begin
    int d;
    d         = 0;
    state_d   = state_q;
    k_d       = k_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    clear_d   = 1'b0;
    stream_en = 1'b0;
    edge_k    = '0;
    a_d       = a_q;
    b_d       = b_q;

    // Output registers load the value of the cycle being entered, so the edge
    // lanes are computed from the stream index of the next cycle.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          clear_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d   = STREAM;
        k_d       = '0;
        busy_d    = 1'b1;
        stream_en = 1'b1;
        edge_k    = '0;
      end
      STREAM: begin
        busy_d = 1'b1;
        if (k_q == K_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          k_d       = k_q + KW'(1);
          stream_en = 1'b1;
          edge_k    = k_q + KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q == IDLE && load_en && int'(load_addr) < DEPTH) begin
      if (load_sel) b_d[load_addr] = load_data;
      else          a_d[load_addr] = load_data;
    end

    a_edge_d = '0;
    b_edge_d = '0;
    if (stream_en) begin
      for (int i = 0; i < N; i++) begin
        d = int'(edge_k) - i;
        if (d >= 0 && d < N) begin
          a_edge_d[i*WIDTH +: WIDTH] = a_q[i*N + d];
          b_edge_d[i*WIDTH +: WIDTH] = b_q[d*N + i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clear_q  <= 1'b0;
      a_edge_q <= '0;
      b_edge_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clear_q  <= clear_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Clear  = clear_q;
  assign A_EDGE = a_edge_q;
  assign B_EDGE = b_edge_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_edge_feeder.sv
`default_nettype none
// Scoreboard bench for systolic_edge_feeder, with a behavioural 3x3 PE array on its edges.
module tb_systolic_edge_feeder;
  localparam int W  = 4;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int LANES = N*W;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             load_en = 1'b0;
  logic             load_sel = 1'b0;
  logic [AW-1:0]    load_addr = '0;
  logic [W-1:0]     load_data = '0;
  logic             start = 1'b0;
  logic             busy, done, Clear;
  logic [LANES-1:0] A_EDGE, B_EDGE;

  systolic_edge_feeder #(.WIDTH(W), .N(N), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .start(start),
    .busy(busy), .done(done), .Clear(Clear), .A_EDGE(A_EDGE), .B_EDGE(B_EDGE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             clr;
    logic             dn;
    logic [LANES-1:0] ea;
    logic [LANES-1:0] eb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ma [N*N];
  int mb [N*N];
  int exp_prod [N][N];
  int pa [N][N];
  int pb [N][N];
  int acc [N][N];

  // Hand-derived lanes (lane 0 in the low nibble) for A = 1..9, B = identity.
  localparam logic [LANES-1:0] HA [7] = '{12'h001, 12'h042, 12'h753, 12'h860, 12'h900, 12'h000, 12'h000};
  localparam logic [LANES-1:0] HB [7] = '{12'h001, 12'h000, 12'h010, 12'h000, 12'h100, 12'h000, 12'h000};

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [LANES-1:0] model_a(int k);
    logic [LANES-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (k - i >= 0 && k - i < N) r[i*W +: W] = W'(ma[i*N + k - i]);
    return r;
  endfunction

  function automatic logic [LANES-1:0] model_b(int k);
    logic [LANES-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (k - j >= 0 && k - j < N) r[j*W +: W] = W'(mb[(k - j)*N + j]);
    return r;
  endfunction

  function automatic void push_job(bit hand);
    exp_t e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_prod[i][j] = 0;
        for (int m = 0; m < N; m++) exp_prod[i][j] += ma[i*N + m] * mb[m*N + j];
      end
    e = '{clr: 1'b1, dn: 1'b0, ea: '0, eb: '0};
    q.push_back(e);
    for (int k = 0; k < 3*N - 2; k++) begin
      e.clr = 1'b0;
      e.ea  = hand ? HA[k] : model_a(k);
      e.eb  = hand ? HB[k] : model_b(k);
      q.push_back(e);
    end
    e = '{clr: 1'b0, dn: 1'b1, ea: '0, eb: '0};
    q.push_back(e);
  endfunction

  // Behavioural output-stationary PE array fed by the edges.
  always @(posedge CLK or negedge RST) begin
    int ain, bin;
    if (!RST) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin pa[i][j] <= 0; pb[i][j] <= 0; acc[i][j] <= 0; end
    end else if (Clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin pa[i][j] <= 0; pb[i][j] <= 0; acc[i][j] <= 0; end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (j == 0) ain = int'(A_EDGE[i*W +: W]); else ain = pa[i][j-1];
          if (i == 0) bin = int'(B_EDGE[j*W +: W]); else bin = pb[i-1][j];
          acc[i][j] <= acc[i][j] + ain * bin;
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
        end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (RST && busy) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_busy: got busy=1 expected no pending job at %0t", $time);
      end else begin
        e = q.pop_front();
        check("clear", int'(Clear), int'(e.clr));
        check("done", int'(done), int'(e.dn));
        check("a_edge", int'(A_EDGE), int'(e.ea));
        check("b_edge", int'(B_EDGE), int'(e.eb));
        if (done) begin
          done_cnt++;
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) check($sformatf("result_%0d_%0d", i, j), acc[i][j], exp_prod[i][j]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write(logic sel, int addr, int data);
    load_en = 1'b1; load_sel = sel; load_addr = AW'(addr); load_data = W'(data);
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    bit ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (q.size() == 0 && !busy) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending entries expected 0", name, q.size());
    end
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_clear"}, int'(Clear), 0);
    check({tag, "_a_edge"}, int'(A_EDGE), 0);
    check({tag, "_b_edge"}, int'(B_EDGE), 0);
  endtask

  initial begin
    repeat (2) tick();
    check_quiet("reset");
    RST = 1'b1;
    tick();

    // Job 1: skew pattern, B = identity, result equals A.
    for (int i = 0; i < N*N; i++) begin
      ma[i] = i + 1;
      mb[i] = (i % (N + 1) == 0) ? 1 : 0;
      write(1'b0, i, ma[i]);
      write(1'b1, i, mb[i]);
    end
    push_job(1'b1);
    pulse_start();
    wait_idle("job1");

    // Job 2: B = all 2s; start and a write to A[0][0] during STREAM must be dropped.
    for (int i = 0; i < N*N; i++) begin
      mb[i] = 2;
      write(1'b1, i, 2);
    end
    push_job(1'b0);
    pulse_start();
    repeat (4) tick();
    start = 1'b1; load_en = 1'b1; load_sel = 1'b0; load_addr = '0; load_data = 4'd15;
    tick();
    start = 1'b0; load_en = 1'b0;
    wait_idle("job2");

    // Job 3: out-of-range address ignored, then A[2][2] = 11 loaded with start.
    write(1'b1, 9, 13);
    ma[8] = 11;
    push_job(1'b0);
    load_en = 1'b1; load_sel = 1'b0; load_addr = 4'd8; load_data = 4'd11; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    wait_idle("job3");

    // Job 4: aborted by reset mid-STREAM; storage and outputs clear at once.
    push_job(1'b0);
    pulse_start();
    repeat (3) tick();
    RST = 1'b0;
    #1;
    check_quiet("abort");
    q.delete();
    for (int i = 0; i < N*N; i++) begin ma[i] = 0; mb[i] = 0; end
    repeat (2) tick();
    RST = 1'b1;
    tick();

    // Job 5: all-zero operands after the abort.
    push_job(1'b0);
    pulse_start();
    wait_idle("job5");

    check("done_count", done_cnt, 4);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
